// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel-rate enable, h/v position counters, sync pins,
// active-video flag, frame-start strobe and a programmable frame-rate tick.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_ACTIVE = 0,
    parameter int TICK_FRAMES = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pclk_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       tick
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
        end
        if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be in 2..16");
        end
        if (TICK_FRAMES < 1 || TICK_FRAMES > 255) begin : g_bad_tick
            $error("vga_timing_gen: TICK_FRAMES must be in 1..255");
        end
    endgenerate

    // Compare in 11 bits so a 1024-wide region still decodes correctly.
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [10:0]      H_VIS     = 11'(H_VISIBLE);
    localparam logic [10:0]      V_VIS     = 11'(V_VISIBLE);
    localparam logic [10:0]      HS_START  = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0]      HS_END    = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0]      VS_START  = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0]      VS_END    = 11'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [7:0]       TICK_LAST = 8'(TICK_FRAMES - 1);
    localparam logic             SYNC_ON   = 1'(SYNC_ACTIVE);
    localparam logic             SYNC_OFF  = ~SYNC_ON;

    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       frm_cnt;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;
    logic             frame_wrap;
    logic             div_last;

    assign div_last = (div_cnt == DIV_LAST);

    always_comb begin
        h_nxt      = h_cnt + 10'd1;
        v_nxt      = v_cnt;
        frame_wrap = 1'b0;
        if (h_cnt == H_LAST) begin
            h_nxt = 10'd0;
            if (v_cnt == V_LAST) begin
                v_nxt      = 10'd0;
                frame_wrap = 1'b1;
            end else begin
                v_nxt = v_cnt + 10'd1;
            end
        end
    end

    // All outputs change on the same edge as the counters; decodes use the
    // next-state position so they line up with h_cnt/v_cnt without skew.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt     <= '0;
            frm_cnt     <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            pclk_en     <= 1'b0;
            valid       <= 1'b0;
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            frame_start <= 1'b0;
            tick        <= 1'b0;
        end else begin
            pclk_en     <= 1'b0;
            frame_start <= 1'b0;
            tick        <= 1'b0;
            if (div_last) begin
                div_cnt <= '0;
                pclk_en <= 1'b1;
                h_cnt   <= h_nxt;
                v_cnt   <= v_nxt;
                valid   <= ({1'b0, h_nxt} < H_VIS) && ({1'b0, v_nxt} < V_VIS);
                hsync   <= (({1'b0, h_nxt} >= HS_START) && ({1'b0, h_nxt} < HS_END))
                           ? SYNC_ON : SYNC_OFF;
                vsync   <= (({1'b0, v_nxt} >= VS_START) && ({1'b0, v_nxt} < VS_END))
                           ? SYNC_ON : SYNC_OFF;
                if (frame_wrap) begin
                    frame_start <= 1'b1;
                    if (frm_cnt == TICK_LAST) begin
                        tick    <= 1'b1;
                        frm_cnt <= '0;
                    end else begin
                        frm_cnt <= frm_cnt + 8'd1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two shrunken-raster instances checked
// every clock against a position-from-elapsed-time reference model.
module tb_vga_timing_gen;
    // Instance A: active-low sync, tick every 3rd frame.
    localparam int A_DIV = 3, A_HV = 8, A_HFP = 2, A_HS = 3, A_HBP = 2;
    localparam int A_VV = 4, A_VFP = 1, A_VS = 2, A_VBP = 1, A_SA = 0, A_TF = 3;
    // Instance B: fastest divider, active-high sync, tick on every frame.
    localparam int B_DIV = 2, B_HV = 6, B_HFP = 1, B_HS = 2, B_HBP = 1;
    localparam int B_VV = 3, B_VFP = 1, B_VS = 1, B_VBP = 2, B_SA = 1, B_TF = 1;

    typedef struct packed {
        logic       pclk_en;
        logic [9:0] h;
        logic [9:0] v;
        logic       valid;
        logic       hsync;
        logic       vsync;
        logic       fs;
        logic       tick;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       pclk_en_a, valid_a, hsync_a, vsync_a, fs_a, tick_a;
    logic [9:0] h_cnt_a, v_cnt_a;
    logic       pclk_en_b, valid_b, hsync_b, vsync_b, fs_b, tick_b;
    logic [9:0] h_cnt_b, v_cnt_b;

    vga_timing_gen #(
        .CLK_DIV(A_DIV), .H_VISIBLE(A_HV), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_VISIBLE(A_VV), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
        .SYNC_ACTIVE(A_SA), .TICK_FRAMES(A_TF)
    ) dut_a (
        .clk(clk), .reset(reset), .pclk_en(pclk_en_a), .h_cnt(h_cnt_a), .v_cnt(v_cnt_a),
        .valid(valid_a), .hsync(hsync_a), .vsync(vsync_a), .frame_start(fs_a), .tick(tick_a)
    );

    vga_timing_gen #(
        .CLK_DIV(B_DIV), .H_VISIBLE(B_HV), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_VISIBLE(B_VV), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .SYNC_ACTIVE(B_SA), .TICK_FRAMES(B_TF)
    ) dut_b (
        .clk(clk), .reset(reset), .pclk_en(pclk_en_b), .h_cnt(h_cnt_b), .v_cnt(v_cnt_b),
        .valid(valid_b), .hsync(hsync_b), .vsync(vsync_b), .frame_start(fs_b), .tick(tick_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected outputs after n clock edges since reset release, derived purely
    // from how many pixel periods have elapsed.
    function automatic obs_t model(input int n, input int div, input int hv, input int hfp,
                                   input int hs, input int hbp, input int vv, input int vfp,
                                   input int vs, input int vbp, input int sa, input int tf);
        obs_t e;
        int ht, vt, fr, k, h, v;
        logic on;
        ht = hv + hfp + hs + hbp;
        vt = vv + vfp + vs + vbp;
        fr = ht * vt;
        k  = n / div;
        h  = k % ht;
        v  = (k / ht) % vt;
        on = 1'(sa);
        e.pclk_en = (n > 0) && (n % div == 0);
        e.h       = 10'(h);
        e.v       = 10'(v);
        e.valid   = (k > 0) && (h < hv) && (v < vv);
        e.hsync   = ((k > 0) && (h >= hv + hfp) && (h < hv + hfp + hs)) ? on : ~on;
        e.vsync   = ((k > 0) && (v >= vv + vfp) && (v < vv + vfp + vs)) ? on : ~on;
        e.fs      = e.pclk_en && (k % fr == 0);
        e.tick    = e.fs && ((k / fr) % tf == 0);
        return e;
    endfunction

    task automatic compare_obs(input string who, input obs_t got, input obs_t exp);
        check({who, ".pclk_en"}, 32'(got.pclk_en), 32'(exp.pclk_en));
        check({who, ".h_cnt"},   32'(got.h),       32'(exp.h));
        check({who, ".v_cnt"},   32'(got.v),       32'(exp.v));
        check({who, ".valid"},   32'(got.valid),   32'(exp.valid));
        check({who, ".hsync"},   32'(got.hsync),   32'(exp.hsync));
        check({who, ".vsync"},   32'(got.vsync),   32'(exp.vsync));
        check({who, ".frame_start"}, 32'(got.fs),  32'(exp.fs));
        check({who, ".tick"},    32'(got.tick),    32'(exp.tick));
    endtask

    obs_t qa[$];
    obs_t qb[$];
    int   n = 0;

    // Stimulus side: each edge is the stimulus; push what should follow it.
    always @(posedge clk) begin : model_p
        int nn;
        nn = reset ? 0 : n + 1;
        n <= nn;
        qa.push_back(model(nn, A_DIV, A_HV, A_HFP, A_HS, A_HBP, A_VV, A_VFP, A_VS, A_VBP, A_SA, A_TF));
        qb.push_back(model(nn, B_DIV, B_HV, B_HFP, B_HS, B_HBP, B_VV, B_VFP, B_VS, B_VBP, B_SA, B_TF));
    end

    int fs_cnt_a = 0, tick_cnt_a = 0, fs_cnt_b = 0, tick_cnt_b = 0;

    always @(negedge clk) begin : check_p
        obs_t ga, gb, ea, eb;
        if (qa.size() > 0 && qb.size() > 0) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            ga.pclk_en = pclk_en_a; ga.h = h_cnt_a; ga.v = v_cnt_a; ga.valid = valid_a;
            ga.hsync = hsync_a; ga.vsync = vsync_a; ga.fs = fs_a; ga.tick = tick_a;
            gb.pclk_en = pclk_en_b; gb.h = h_cnt_b; gb.v = v_cnt_b; gb.valid = valid_b;
            gb.hsync = hsync_b; gb.vsync = vsync_b; gb.fs = fs_b; gb.tick = tick_b;
            compare_obs("a", ga, ea);
            compare_obs("b", gb, eb);
            if (fs_a === 1'b1)   fs_cnt_a++;
            if (tick_a === 1'b1) tick_cnt_a++;
            if (fs_b === 1'b1)   fs_cnt_b++;
            if (tick_b === 1'b1) tick_cnt_b++;
        end
    end

    initial begin : main
        bit found;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Seven frames of instance A (360 clks each) plus a little margin.
        repeat (2530) @(negedge clk);
        #1;
        check("a.frame_start_count", 32'(fs_cnt_a), 32'd7);
        check("a.tick_count", 32'(tick_cnt_a), 32'd2);
        check("b.frame_start_count", 32'(fs_cnt_b), 32'd18);
        check("b.tick_count", 32'(tick_cnt_b), 32'd18);

        // Hit reset while A is inside both sync pulses.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (hsync_a === 1'b0 && vsync_a === 1'b0) found = 1'b1;
        end
        check("a.sync_window_reached", 32'(found), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("a.async_h_cnt", 32'(h_cnt_a), 32'd0);
        check("a.async_v_cnt", 32'(v_cnt_a), 32'd0);
        check("a.async_hsync", 32'(hsync_a), 32'd1);
        check("a.async_vsync", 32'(vsync_a), 32'd1);
        check("a.async_valid", 32'(valid_a), 32'd0);
        check("a.async_frame_start", 32'(fs_a), 32'd0);
        check("a.async_tick", 32'(tick_a), 32'd0);
        check("b.async_hsync", 32'(hsync_b), 32'd0);
        check("b.async_vsync", 32'(vsync_b), 32'd0);

        repeat (2) @(negedge clk);
        fs_cnt_a = 0;
        tick_cnt_a = 0;
        reset = 1'b0;
        // Restart runs a full frame of A; its first tick needs three frames.
        repeat (400) @(negedge clk);
        #1;
        check("a.restart_frame_start_count", 32'(fs_cnt_a), 32'd1);
        check("a.restart_tick_count", 32'(tick_cnt_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
